// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the ID-stage branch/flag controller.
package branch_ctrl_pkg;

    // Two-state resolver: normal resolution, or one cycle spent waiting
    // for a load result that a CBZ in ID depends on.
    typedef enum logic [0:0] {
        RESOLVE   = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    // XZR reads as zero and is never written, so it never causes a hazard.
    localparam int ZERO_REG = 31;

    // NZCV bit positions within the 4-bit flag vector {N,Z,C,V}.
    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Signed less-than after a compare: N differs from V.
    function automatic logic cond_lt(input logic [FLAG_W-1:0] f);
        return f[FLAG_N] ^ f[FLAG_V];
    endfunction

endpackage

// File: rtl/branch_flag_ctrl_flag_reg.sv
// Architectural NZCV register: per-bit enable D flip-flops, synchronous reset.
module flag_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] d,
    output logic [3:0] q
);
    import branch_ctrl_pkg::*;

    logic [FLAG_W-1:0] q_reg;

    generate
        for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_bit
            // Each flag bit clears on reset and loads only when enabled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg[gi] <= 1'b0;
                end else if (en) begin
                    q_reg[gi] <= d[gi];
                end
            end
        end
    endgenerate

    assign q = q_reg;

endmodule

// File: rtl/branch_flag_ctrl.sv
// ID-stage branch resolution (B, B.LT, CBZ) with the NZCV flag register and
// a one-cycle load-use stall for CBZ. No flush: one branch delay slot.
module branch_flag_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_setFlags,
    input  logic [3:0]            ex_flagsIn,
    input  logic                  ex_regWrite,
    input  logic                  ex_memRead,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_isB,
    input  logic                  id_isBLT,
    input  logic                  id_isCBZ,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_cbzZero,
    output logic [3:0]            flags,
    output logic                  takeBranch,
    output logic                  stall
);
    import branch_ctrl_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    state_t            state_reg;
    state_t            state_next;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] eff_flags;
    logic              load_haz;
    logic              blt_taken;

    // Flags update whenever EX sets them; a stall does not gate the write.
    flag_reg u_flag_reg (
        .clk   (clk),
        .reset (reset),
        .en    (ex_setFlags),
        .d     (ex_flagsIn),
        .q     (flags_q)
    );

    assign flags     = flags_q;
    // Forward EX flags so SUBS followed by B.LT resolves without a stall.
    assign eff_flags = ex_setFlags ? ex_flagsIn : flags_q;
    assign blt_taken = cond_lt(eff_flags);
    // CBZ operand is still being loaded by the instruction in EX.
    assign load_haz  = id_isCBZ & ex_memRead & ex_regWrite &
                       (ex_rd == id_rt) & (id_rt != ZERO_ADDR);

    // Resolver state advances every cycle; reset drops any pending CBZ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RESOLVE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Branch decision, stall request and next state.
    always_comb begin
        state_next = RESOLVE;
        takeBranch = 1'b0;
        stall      = 1'b0;
        if (!reset) begin
            case (state_reg)
                RESOLVE: begin
                    if (load_haz) begin
                        stall      = 1'b1;
                        state_next = WAIT_LOAD;
                    end else if (id_isCBZ) begin
                        // CBZ wins over B.LT and B on an illegal multi-decode.
                        takeBranch = id_cbzZero;
                    end else if (id_isBLT) begin
                        takeBranch = blt_taken;
                    end else begin
                        takeBranch = id_isB;
                    end
                end
                WAIT_LOAD: begin
                    // Held instruction is the CBZ; operand now comes from MEM.
                    takeBranch = id_isCBZ & id_cbzZero;
                    state_next = RESOLVE;
                end
                default: begin
                    state_next = RESOLVE;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_flag_ctrl.md
Name: branch_flag_ctrl

Overview:
Branch-resolution controller for the pipelined LEGv8 CPU. It owns the architectural NZCV flag register and decides B, B.LT and CBZ in the ID stage. It uses the zero-detect result on the forwarded CBZ operand and the EX-stage ALU flags. It stalls ID/IF for one cycle when a CBZ operand comes from a load in EX. There is no flush: the architecture has one branch delay slot.

Parameters:
REG_ADDR_W, 5, register address width
ZERO_REG, 31, index of XZR (never a hazard source)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ex_setFlags  input  1  instruction in EX writes flags (ADDS/SUBS)
ex_flagsIn  input  4  ALU flags in EX, {N,Z,C,V}
ex_regWrite  input  1  EX instruction writes a register
ex_memRead  input  1  EX instruction is LDUR
ex_rd  input  REG_ADDR_W  EX destination register
id_isB  input  1  unconditional branch in ID
id_isBLT  input  1  B.LT in ID
id_isCBZ  input  1  CBZ in ID
id_rt  input  REG_ADDR_W  CBZ source register
id_cbzZero  input  1  zero-detect of forwarded CBZ operand (1 = operand is 0)
flags  output  4  registered NZCV, {N,Z,C,V}
takeBranch  output  1  ID branch is taken this cycle
stall  output  1  hold PC and IF/ID; insert bubble into ID/EX

Behaviour:
- Reset (clk edge with reset=1): flags=4'b0000; state=RESOLVE. While reset=1: takeBranch=0, stall=0, regardless of other inputs.
- Flag register: on each clk edge with reset=0 and ex_setFlags=1, flags <= ex_flagsIn. Otherwise flags holds. Latency is 1 cycle.
- Effective flags for ID (combinational): ex_flagsIn if ex_setFlags=1, else flags. This forwards SUBS->B.LT back-to-back with no stall.
- B.LT condition: effN != effV.
- Load hazard (combinational): loadHaz = id_isCBZ & ex_memRead & ex_regWrite & (ex_rd==id_rt) & (id_rt!=ZERO_REG).
- FSM states:
  - RESOLVE:
    - If loadHaz: stall=1, takeBranch=0, next=WAIT_LOAD.
    - Otherwise stall=0, next=RESOLVE, and takeBranch = id_isB | (id_isBLT & (effN^effV)) | (id_isCBZ & id_cbzZero).
  - WAIT_LOAD:
    - stall=0. The operand is now forwarded from MEM.
    - takeBranch = id_isCBZ & id_cbzZero. id_isB and id_isBLT are ignored here because the held instruction is the CBZ.
    - next=RESOLVE unconditionally; a second stall is never issued for the same instruction.
- Simultaneous decode flags (illegal encoding): priority is CBZ > B.LT > B. The bench flags a warning.
- ALU-result (non-load) dependency in EX: no stall. Forwarding upstream supplies id_cbzZero in the same cycle.
- Bubble in EX during WAIT_LOAD has ex_setFlags=0, so flags are unchanged.
- Reset asserted in WAIT_LOAD: the next state is RESOLVE, the pending CBZ is dropped, and flags clear.
- ex_setFlags during stall (load in EX never sets flags) is handled identically; the update is not gated by stall.

Decomposition:
- Package branch_ctrl_pkg:
  - enum for state {RESOLVE, WAIT_LOAD}
  - ZERO_REG
  - flag bit indices N=3, Z=2, C=1, V=0
- One sub-module, flag_reg: 4-bit enable D-register with synchronous reset, instantiated once.
- FSM, hazard compare (5-bit equality) and branch mux live in branch_flag_ctrl.

Test Plan:
- Reset held 2 cycles with ex_setFlags=1, ex_flagsIn=4'b1111 -> flags=0000, stall=0, takeBranch=0 throughout. Release -> next edge flags=1111.
- SUBS in EX with ex_flagsIn=4'b1000 (N=1,V=0) while B.LT in ID, flags reg=0000 -> takeBranch=1 same cycle, stall=0. Next edge flags=1000. Repeat with 4'b1001 -> takeBranch=0.
- LDUR X3 in EX (memRead=1, rd=3), CBZ X3 in ID -> cycle 1: stall=1, takeBranch=0. Cycle 2 (WAIT_LOAD): id_cbzZero=1 -> takeBranch=1, stall=0. Cycle 3: back to RESOLVE.
- Same as above but id_rt=31 and ex_rd=31 -> no stall; takeBranch follows id_cbzZero immediately.
- ADD X5 in EX (memRead=0, rd=5), CBZ X5, id_cbzZero=0 -> stall=0, takeBranch=0.
- Enter WAIT_LOAD, assert reset that cycle -> takeBranch=0; next cycle state=RESOLVE, flags=0000. id_isB=1 after release -> takeBranch=1.
